// File: rtl/ram_boot_loader.sv
// ram_boot_loader
//   Front end of the 64 KiB system RAM. The single RAM port is shared between
//   the 6502 CPU bus and a byte-stream loader fed by the UART receiver. The
//   loader parses framed download packets and writes their payload into RAM.
//   The CPU is held until the first good frame has been committed.
//
//   Frame: SYNC_BYTE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes
//          [, CHK when LOADER_CHECKSUM_EN is defined]
//
//   Optional feature (macro LOADER_CHECKSUM_EN):
//     When defined, an 8-bit running sum over the data bytes is kept.
//     A trailing CHK byte must satisfy sum + CHK == 0 (mod 256) for the frame
//     to commit. When undefined, frames end after the last data byte.
//
// Parameters
//   SYNC_BYTE  frame start marker
//   TIMEOUT    max idle clk cycles between bytes inside a frame
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   rx_data    in   [7:0]  received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   cpu_addr   in   [15:0] CPU address
//   cpu_we     in   CPU write enable
//   cpu_re     in   CPU read enable
//   cpu_wdata  in   [7:0]  CPU write data
//   mem_addr   out  [15:0] RAM address
//   mem_we     out  RAM write enable
//   mem_re     out  RAM read enable
//   mem_wdata  out  [7:0]  RAM write data
//   cpu_hold   out  high while the CPU must be held
//   load_done  out  one-cycle pulse, frame committed
//   load_error out  one-cycle pulse, frame aborted

module ram_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic        cpu_re,
  input  logic [7:0]  cpu_wdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic        mem_re,
  output logic [7:0]  mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_ADDR_LO = 4'd1;
  localparam logic [3:0] S_ADDR_HI = 4'd2;
  localparam logic [3:0] S_LEN_LO  = 4'd3;
  localparam logic [3:0] S_LEN_HI  = 4'd4;
  localparam logic [3:0] S_DATA    = 4'd5;
  localparam logic [3:0] S_DONE    = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK     = 4'd6;
  // Where a frame goes once its payload (possibly empty) has been taken.
  localparam logic [3:0] S_POST    = S_CHK;
`else
  localparam logic [3:0] S_POST    = S_DONE;
`endif

  logic [3:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   rem_q, rem_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          first_ok_q, first_ok_d;
  logic          wr_we_q, wr_we_d;
  logic [15:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          in_frame;
  logic          timed_out;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    chk_total;
`endif

  // States in which the inter-byte timeout is armed.
  assign in_frame = (state_q != S_IDLE) && (state_q != S_DONE) &&
                    (state_q != S_ERR);

`ifdef LOADER_CHECKSUM_EN
  assign chk_total = sum_q + rx_data;
`endif

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tcnt_d     = '0;
    first_ok_d = first_ok_q;
    wr_we_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    timed_out  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_d      = sum_q;
`endif

    // Idle-cycle counter: restarts on every received byte, aborts the frame
    // after TIMEOUT consecutive cycles with no byte.
    if (in_frame && !rx_valid) begin
      if (tcnt_q == TIMEOUT_LAST) begin
        timed_out = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d = S_ADDR_LO;
`ifdef LOADER_CHECKSUM_EN
          sum_d   = 8'h00;
`endif
        end
      end
      S_ADDR_LO: begin
        if (rx_valid) begin
          addr_d[7:0] = rx_data;
          state_d     = S_ADDR_HI;
        end
      end
      S_ADDR_HI: begin
        if (rx_valid) begin
          addr_d[15:8] = rx_data;
          state_d      = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          rem_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          rem_d[15:8] = rx_data;
          if ({rx_data, rem_q[7:0]} == 16'h0000) begin
            state_d = S_POST;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        // The write is registered so it reaches the RAM exactly one cycle
        // after the strobe; the final write therefore lands in DONE/CHK.
        if (rx_valid) begin
          wr_we_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx_data;
          addr_d    = addr_q + 16'd1;
          rem_d     = rem_q - 16'd1;
`ifdef LOADER_CHECKSUM_EN
          sum_d     = sum_q + rx_data;
`endif
          if (rem_q == 16'd1) begin
            state_d = S_POST;
          end
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (rx_valid) begin
          state_d = (chk_total == 8'h00) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE: begin
        first_ok_d = 1'b1;
        state_d    = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (timed_out) begin
      state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 16'h0000;
      rem_q      <= 16'h0000;
      tcnt_q     <= '0;
      first_ok_q <= 1'b0;
      wr_we_q    <= 1'b0;
      wr_addr_q  <= 16'h0000;
      wr_data_q  <= 8'h00;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      tcnt_q     <= tcnt_d;
      first_ok_q <= first_ok_d;
      wr_we_q    <= wr_we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // In IDLE the CPU drives the RAM combinationally; otherwise the loader owns
  // the port, reads are suppressed and only the registered strobe writes.
  always_comb begin
    if (state_q == S_IDLE) begin
      mem_addr  = cpu_addr;
      mem_we    = cpu_we;
      mem_re    = cpu_re;
      mem_wdata = cpu_wdata;
    end else begin
      mem_addr  = wr_addr_q;
      mem_we    = wr_we_q;
      mem_re    = 1'b0;
      mem_wdata = wr_data_q;
    end
  end

  assign cpu_hold   = !first_ok_q || (state_q != S_IDLE);
  assign load_done  = (state_q == S_DONE);
  assign load_error = (state_q == S_ERR);

endmodule

// File: tb/tb_ram_boot_loader.sv
// Directed self-checking bench for ram_boot_loader.
module tb_ram_boot_loader;

  localparam int unsigned TO = 16;

  logic        clk;
  logic        reset_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_wdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        load_done;
  logic        load_error;

  int testsRun    = 0;
  int testsFailed = 0;
  int doneCount   = 0;
  int errCount    = 0;
  logic [7:0] lastChkSum;

  ram_boot_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_wdata(cpu_wdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters, sampled at the end of each cycle.
  always @(posedge clk) begin
    if (load_done === 1'b1) doneCount <= doneCount + 1;
    if (load_error === 1'b1) errCount <= errCount + 1;
  end

  // Drive one byte for one cycle; returns at the negedge after it was sampled.
  task automatic sendByte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Trailing checksum byte when the feature is built in.
  task automatic sendChk(input logic [7:0] sum);
    lastChkSum = sum;
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'h00 - sum);
`endif
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cpu_addr = 16'hBEEF; cpu_we = 1'b1; cpu_re = 1'b1; cpu_wdata = 8'h3C;
    repeat (2) @(negedge clk);
    testsRun++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got hold=%b done=%b err=%b expected 1 0 0",
               cpu_hold, load_done, load_error);
    end
    testsRun++;
    if (mem_addr !== 16'hBEEF || mem_we !== 1'b1 || mem_re !== 1'b1 || mem_wdata !== 8'h3C) begin
      testsFailed++;
      $display("[TB] FAIL reset_passthrough: got %h %b %b %h expected beef 1 1 3c",
               mem_addr, mem_we, mem_re, mem_wdata);
    end
    cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    reset_n = 1'b1;
  endtask

  task automatic test_timeout();
    int cycles;
    int e0;
    logic seen;
    e0 = errCount;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h10);
    sendByte(8'h05); sendByte(8'h00); sendByte(8'h01);
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h1000 || mem_wdata !== 8'h01) begin
      testsFailed++;
      $display("[TB] FAIL timeout_write: got %b %h %h expected 1 1000 01",
               mem_we, mem_addr, mem_wdata);
    end
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 3 * TO) begin
      @(negedge clk);
      cycles++;
      if (load_error === 1'b1) seen = 1'b1;
    end
    testsRun++;
    if (!seen || cycles != TO) begin
      testsFailed++;
      $display("[TB] FAIL timeout_latency: got seen=%b cycles=%0d expected 1 %0d",
               seen, cycles, TO);
    end
    testsRun++;
    if (cpu_hold !== 1'b1 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL timeout_err_cycle: got hold=%b we=%b expected 1 0", cpu_hold, mem_we);
    end
    @(negedge clk);
    cpu_addr = 16'h4321;
    #1;
    testsRun++;
    if (cpu_hold !== 1'b1 || mem_addr !== 16'h4321 || errCount - e0 != 1) begin
      testsFailed++;
      $display("[TB] FAIL timeout_idle: got hold=%b addr=%h errs=%0d expected 1 4321 1",
               cpu_hold, mem_addr, errCount - e0);
    end
    cpu_addr = 16'h0000;
  endtask

  task automatic test_basic_frame();
    logic [7:0] d [3];
    int d0;
    d = '{8'h11, 8'h22, 8'h33};
    d0 = doneCount;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02); sendByte(8'h03); sendByte(8'h00);
    testsRun++;
    if (cpu_hold !== 1'b1 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL basic_header: got hold=%b we=%b expected 1 0", cpu_hold, mem_we);
    end
    for (int i = 0; i < 3; i++) begin
      sendByte(d[i]);
      testsRun++;
      if (mem_we !== 1'b1 || mem_addr !== 16'(16'h0200 + i) || mem_wdata !== d[i]) begin
        testsFailed++;
        $display("[TB] FAIL basic_write%0d: got %b %h %h expected 1 %h %h",
                 i, mem_we, mem_addr, mem_wdata, 16'(16'h0200 + i), d[i]);
      end
    end
    sendChk(8'h66);
    testsRun++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL basic_done: got done=%b hold=%b expected 1 1", load_done, cpu_hold);
    end
    @(negedge clk);
    testsRun++;
    if (cpu_hold !== 1'b0 || load_done !== 1'b0 || doneCount - d0 != 1) begin
      testsFailed++;
      $display("[TB] FAIL basic_release: got hold=%b done=%b pulses=%0d expected 0 0 1",
               cpu_hold, load_done, doneCount - d0);
    end
  endtask

  task automatic test_wrap();
    sendByte(8'hA5); sendByte(8'hFF); sendByte(8'hFF); sendByte(8'h02); sendByte(8'h00);
    sendByte(8'hAA);
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 16'hFFFF || mem_wdata !== 8'hAA) begin
      testsFailed++;
      $display("[TB] FAIL wrap_ffff: got %b %h %h expected 1 ffff aa", mem_we, mem_addr, mem_wdata);
    end
    sendByte(8'hBB);
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0000 || mem_wdata !== 8'hBB) begin
      testsFailed++;
      $display("[TB] FAIL wrap_0000: got %b %h %h expected 1 0000 bb", mem_we, mem_addr, mem_wdata);
    end
    sendChk(8'h65);
    testsRun++;
    if (load_done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL wrap_done: got %b expected 1", load_done);
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h60); sendByte(8'h00); sendByte(8'h00);
    sendChk(8'h00);
    testsRun++;
    if (load_done !== 1'b1 || mem_we !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_len: got done=%b we=%b expected 1 0", load_done, mem_we);
    end
    @(negedge clk);
  endtask

  task automatic test_passthrough();
    cpu_addr = 16'h1234; cpu_we = 1'b1; cpu_re = 1'b1; cpu_wdata = 8'h5A;
    #1;
    testsRun++;
    if (mem_addr !== 16'h1234 || mem_we !== 1'b1 || mem_re !== 1'b1 ||
        mem_wdata !== 8'h5A || cpu_hold !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL pass_idle: got %h %b %b %h hold=%b expected 1234 1 1 5a 0",
               mem_addr, mem_we, mem_re, mem_wdata, cpu_hold);
    end
    sendByte(8'hA5);
    testsRun++;
    if (mem_we !== 1'b0 || mem_re !== 1'b0 || cpu_hold !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pass_blocked: got we=%b re=%b hold=%b expected 0 0 1",
               mem_we, mem_re, cpu_hold);
    end
    sendByte(8'h00); sendByte(8'h30); sendByte(8'h01); sendByte(8'h00); sendByte(8'h77);
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h3000 || mem_wdata !== 8'h77 || cpu_hold !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pass_loader_write: got %b %h %h hold=%b expected 1 3000 77 1",
               mem_we, mem_addr, mem_wdata, cpu_hold);
    end
    sendChk(8'h77);
    testsRun++;
    if (load_done !== 1'b1 || cpu_hold !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pass_done: got done=%b hold=%b expected 1 1", load_done, cpu_hold);
    end
    @(negedge clk);
    testsRun++;
    if (cpu_hold !== 1'b0 || mem_addr !== 16'h1234 || mem_we !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL pass_return: got hold=%b %h %b expected 0 1234 1",
               cpu_hold, mem_addr, mem_we);
    end
    cpu_addr = 16'h0000; cpu_we = 1'b0; cpu_re = 1'b0; cpu_wdata = 8'h00;
  endtask

  task automatic test_reset_midframe();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h40); sendByte(8'h04); sendByte(8'h00);
    sendByte(8'h01); sendByte(8'h02);
    cpu_addr = 16'h5555;
    #1;
    reset_n = 1'b0;
    #1;
    testsRun++;
    if (cpu_hold !== 1'b1 || load_done !== 1'b0 || load_error !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 16'h5555) begin
      testsFailed++;
      $display("[TB] FAIL midreset: got hold=%b done=%b err=%b we=%b addr=%h expected 1 0 0 0 5555",
               cpu_hold, load_done, load_error, mem_we, mem_addr);
    end
    @(negedge clk);
    reset_n = 1'b1;
    cpu_addr = 16'h0000;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h50); sendByte(8'h01); sendByte(8'h00);
    sendByte(8'h99);
    testsRun++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h5000 || mem_wdata !== 8'h99) begin
      testsFailed++;
      $display("[TB] FAIL midreset_refr: got %b %h %h expected 1 5000 99", mem_we, mem_addr, mem_wdata);
    end
    sendChk(8'h99);
    testsRun++;
    if (load_done !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL midreset_done: got %b expected 1", load_done);
    end
    @(negedge clk);
    testsRun++;
    if (cpu_hold !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_release: got %b expected 0", cpu_hold);
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] chk [2];
    chk = '{8'hD0, 8'hD1};
    for (int f = 0; f < 2; f++) begin
      sendByte(8'hA5); sendByte(8'h00); sendByte(8'h03); sendByte(8'h02); sendByte(8'h00);
      sendByte(8'h10);
      testsRun++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 8'h10) begin
        testsFailed++;
        $display("[TB] FAIL chk%0d_w0: got %b %h %h expected 1 0300 10", f, mem_we, mem_addr, mem_wdata);
      end
      sendByte(8'h20);
      testsRun++;
      if (mem_we !== 1'b1 || mem_addr !== 16'h0301 || mem_wdata !== 8'h20) begin
        testsFailed++;
        $display("[TB] FAIL chk%0d_w1: got %b %h %h expected 1 0301 20", f, mem_we, mem_addr, mem_wdata);
      end
      sendByte(chk[f]);
      testsRun++;
      if (load_done !== (f == 0) || load_error !== (f == 1) ||
          mem_we !== 1'b0 || cpu_hold !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL chk%0d_result: got done=%b err=%b we=%b hold=%b expected %b %b 0 1",
                 f, load_done, load_error, mem_we, cpu_hold, f == 0, f == 1);
      end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_timeout();
    test_basic_frame();
    test_wrap();
    test_zero_len();
    test_passthrough();
    test_reset_midframe();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/ram_boot_loader.md
Name: ram_boot_loader

Overview:
- Upstream stage of the 64 KiB system RAM (16-bit addr, 8-bit data, we/re, one clock).
- Muxes the RAM port between the 6502 CPU bus and a byte-stream loader fed by the UART receiver.
- Parses framed download packets and writes their payload into RAM.
- Holds the CPU until the first good frame has been loaded.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 1000000, max idle clk cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- cpu_addr  in  16  CPU address
- cpu_we  in  1  CPU write enable
- cpu_re  in  1  CPU read enable
- cpu_wdata  in  8  CPU write data
- mem_addr  out  16  to RAM addr
- mem_we  out  1  to RAM we
- mem_re  out  1  to RAM re
- mem_wdata  out  8  to RAM data_in
- cpu_hold  out  1  high = CPU held (reset/RDY low)
- load_done  out  1  one-cycle pulse, frame committed
- load_error  out  1  one-cycle pulse, frame aborted

Behaviour:
- Frame format: SYNC_BYTE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, LEN data bytes, then CHK if the optional feature is enabled.
- FSM states: IDLE, ADDR_LO, ADDR_HI, LEN_LO, LEN_HI, DATA, CHK, DONE, ERR.
- IDLE: rx_valid with rx_data==SYNC_BYTE -> ADDR_LO. Other bytes are ignored.
- Header states advance one per rx_valid, latching addr/len little-endian.
- Leaving LEN_HI: if len==0, go to DONE (or CHK when enabled); otherwise go to DATA.
- DATA, on each rx_valid:
  - Register the write: next cycle mem_we=1, mem_addr=cur_addr, mem_wdata=byte. Write latency is exactly 1 cycle after the strobe.
  - cur_addr += 1, wrapping 16'hFFFF -> 16'h0000.
  - remaining -= 1. When the last byte is taken, go to DONE (or CHK).
- DONE: one cycle. The last data write is issued in this cycle, load_done=1, first_ok flag set, then -> IDLE.
- ERR: one cycle. load_error=1, no write issued, then -> IDLE. first_ok is unchanged.
- Timeout:
  - Counter clears on every rx_valid and in IDLE.
  - In any non-IDLE state other than DONE/ERR, reaching TIMEOUT cycles without rx_valid -> ERR.
  - Bytes already written stay in RAM (no rollback).
- Bus ownership:
  - Loader owns RAM whenever state != IDLE. In that case mem_re=0, mem_we is the registered write strobe only, and CPU inputs are ignored.
  - In IDLE, mem_* = cpu_* combinationally (zero added latency for the CPU path).
- cpu_hold = !first_ok | (state != IDLE). The CPU is held through every later frame as well.
- rx_valid during DONE/ERR is dropped.
- Reset, async and mid-frame included:
  - state=IDLE, first_ok=0, counters=0, cpu_hold=1, load_done=0, load_error=0, registered mem_we=0.
  - mem_* follow cpu_* (IDLE passthrough). Partial frames are lost.
- Widths: len and remaining are 16 bits; len=65535 covers all but one byte. Timeout counter is $clog2(TIMEOUT+1) bits.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - 8-bit running sum over all data bytes.
  - After the data phase (or directly after LEN_HI when len==0), CHK waits for one byte.
  - If sum+CHK == 8'h00 (mod 256) -> DONE; otherwise -> ERR.
  - The checksum byte is never written to RAM.
  - The timeout applies in CHK.
- Undefined: CHK state and sum logic are absent; frames end after the data bytes.

Test Plan:
- Reset release, feed A5 00 02 03 00 11 22 33 -> writes 0x0200=11, 0x0201=22, 0x0202=33, each 1 cycle after its strobe. load_done pulses once. cpu_hold 1->0 the cycle after DONE.
- Wrap: A5 FF FF 02 00 AA BB -> 0xFFFF=AA, 0x0000=BB.
- Timeout: A5 00 10 05 00 01, then silence for TIMEOUT cycles -> one write (0x1000=01), load_error pulse, state IDLE, cpu_hold stays 1 (first_ok=0).
- Passthrough: after a good frame, drive cpu_addr=0x1234, cpu_we=1, cpu_wdata=5A -> mem_* equal cpu_* same cycle. Send A5 -> CPU blocked, cpu_hold=1 until the frame ends.
- Reset mid-frame: assert reset_n=0 during DATA -> outputs at reset values immediately; the next frame parses normally from SYNC_BYTE.
- LOADER_CHECKSUM_EN: A5 00 03 02 00 10 20 D0 -> done. Same frame with CHK=D1 -> load_error, data bytes written, cpu_hold=1.
